// File: rtl/stm_gain_writer_if.sv
// Upload/BRAM bus between the gain STM upload logic and stm_gain_writer.
//   master : upstream controller (drives START/IDX/samples, sees status and BRAM side)
//   slave  : stm_gain_writer (accepts samples, drives status and BRAM write port)
interface stm_gain_writer_if;
  logic        START;
  logic [15:0] IDX;
  logic        DIN_VALID;
  logic        DIN_READY;
  logic [7:0]  INTENSITY;
  logic [7:0]  PHASE;
  logic        BUSY;
  logic        DONE;
  logic        BRAM_WE;
  logic [15:0] BRAM_IDX;
  logic [7:0]  BRAM_ADDR;
  logic [63:0] BRAM_WDATA;
  logic [63:0] CHECKSUM;

  modport master (
    output START, IDX, DIN_VALID, INTENSITY, PHASE,
    input  DIN_READY, BUSY, DONE, BRAM_WE, BRAM_IDX, BRAM_ADDR, BRAM_WDATA, CHECKSUM
  );

  modport slave (
    input  START, IDX, DIN_VALID, INTENSITY, PHASE,
    output DIN_READY, BUSY, DONE, BRAM_WE, BRAM_IDX, BRAM_ADDR, BRAM_WDATA, CHECKSUM
  );
endinterface

// File: rtl/stm_gain_writer.sv
// Gain STM writer: packs DEPTH (intensity, phase) samples of one gain index
// into 64-bit words (four 16-bit lanes, {INTENSITY, PHASE}, lane 0 first) and
// writes each completed word to the gain STM BRAM.
// Ports:
//   CLK, RST  - clock, synchronous active-high reset
//   bus       - stm_gain_writer_if.slave: START/IDX frame request, DIN_VALID/
//               DIN_READY sample handshake with INTENSITY/PHASE, BUSY/DONE
//               status, BRAM_WE/BRAM_IDX/BRAM_ADDR/BRAM_WDATA write port,
//               CHECKSUM of the last frame.
// Optional feature: define STM_GAIN_WRITER_CHECKSUM_EN to accumulate the XOR of
// all words written in a frame on CHECKSUM; otherwise CHECKSUM is constant 0.
// DEPTH must be 1..1024 so the word address fits in 8 bits.
module stm_gain_writer #(
  parameter int unsigned DEPTH = 249
) (
  input  logic             CLK,
  input  logic             RST,
  stm_gain_writer_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IDX_W  = 16;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned LAST_N = DEPTH - 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          lane_q, lane_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   wbuf_q, wbuf_d;
  logic                din_ready_q, din_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [IDX_W-1:0]    bram_idx_q, bram_idx_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  logic                start_acc_c;
  logic                accept_c;
  logic                last_c;
  logic                wr_c;
  logic [WORD_W-1:0]   word_c;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    waddr_d     = waddr_q;
    idx_d       = idx_q;
    wbuf_d      = wbuf_q;
    done_d      = 1'b0;
    we_d        = 1'b0;
    bram_idx_d  = bram_idx_q;
    bram_addr_d = bram_addr_q;
    wdata_d     = wdata_q;

    start_acc_c = (state_q == IDLE) && bus.START;
    accept_c    = (state_q == COLLECT) && bus.DIN_VALID && din_ready_q;
    last_c      = (cnt_q == CNT_W'(LAST_N));

    // Lane 0 starts from an empty word so stale lanes never leak forward.
    word_c = (lane_q == 2'd0) ? '0 : wbuf_q;
    word_c[{lane_q, 4'd0} +: 16] = {bus.INTENSITY, bus.PHASE};
    wr_c   = accept_c && ((lane_q == 2'd3) || last_c);

    unique case (state_q)
      IDLE: begin
        if (start_acc_c) begin
          state_d = COLLECT;
          idx_d   = bus.IDX;
          cnt_d   = '0;
          lane_d  = '0;
          waddr_d = '0;
        end
      end
      COLLECT: begin
        if (accept_c) begin
          cnt_d  = cnt_q + CNT_W'(1);
          lane_d = lane_q + 2'd1;
          wbuf_d = word_c;
          if (wr_c) begin
            we_d        = 1'b1;
            bram_idx_d  = idx_q;
            bram_addr_d = waddr_q;
            wdata_d     = word_c;
            waddr_d     = waddr_q + ADDR_W'(1);
          end
          if (last_c) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    din_ready_d = (state_d == COLLECT);
    busy_d      = (state_d == COLLECT);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lane_q      <= '0;
      waddr_q     <= '0;
      idx_q       <= '0;
      wbuf_q      <= '0;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      bram_idx_q  <= '0;
      bram_addr_q <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      waddr_q     <= waddr_d;
      idx_q       <= idx_d;
      wbuf_q      <= wbuf_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      we_q        <= we_d;
      bram_idx_q  <= bram_idx_d;
      bram_addr_q <= bram_addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef STM_GAIN_WRITER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum_q, checksum_d;

  // Running XOR of the words written in the current frame
  always_comb begin
    checksum_d = checksum_q;
    if (start_acc_c) begin
      checksum_d = '0;
    end else if (wr_c) begin
      checksum_d = checksum_q ^ word_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign bus.CHECKSUM = checksum_q;
`else
  assign bus.CHECKSUM = '0;
`endif

  assign bus.DIN_READY  = din_ready_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.BRAM_WE    = we_q;
  assign bus.BRAM_IDX   = bram_idx_q;
  assign bus.BRAM_ADDR  = bram_addr_q;
  assign bus.BRAM_WDATA = wdata_q;

endmodule

// File: tb/tb_stm_gain_writer.sv
// Directed bench for stm_gain_writer: three instances (DEPTH 249, 8, 4) share
// CLK/RST; each BRAM write is logged at the falling edge and compared against
// hand-computed words.
module tb_stm_gain_writer;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  stm_gain_writer_if b249 ();
  stm_gain_writer_if b8 ();
  stm_gain_writer_if b4 ();

  stm_gain_writer #(.DEPTH(249)) u249 (.CLK(CLK), .RST(RST), .bus(b249));
  stm_gain_writer #(.DEPTH(8))   u8   (.CLK(CLK), .RST(RST), .bus(b8));
  stm_gain_writer #(.DEPTH(4))   u4   (.CLK(CLK), .RST(RST), .bus(b4));

  typedef struct packed {
    logic        done;
    logic [15:0] idx;
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t q249[$];
  wr_t q8[$];
  int  done249 = 0;
  int  done8   = 0;
  int  n_cmp   = 0;
  int  n_err   = 0;

`ifdef STM_GAIN_WRITER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  // Write logger, sampled away from the active edge
  always @(negedge CLK) begin
    if (b249.BRAM_WE) q249.push_back(wr_t'({b249.DONE, b249.BRAM_IDX, b249.BRAM_ADDR, b249.BRAM_WDATA}));
    if (b8.BRAM_WE)   q8.push_back(wr_t'({b8.DONE, b8.BRAM_IDX, b8.BRAM_ADDR, b8.BRAM_WDATA}));
    if (b249.DONE) done249++;
    if (b8.DONE)   done8++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected word w of the DEPTH=249 ramp frame
  function automatic logic [63:0] exp249(input int w);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 4 * w + k;
      if (n < 249) d[16*k +: 16] = {~8'(n), 8'(n)};
    end
    return d;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ck;
    int          nw;

    RST = 1'b1;
    b249.START = 1'b0; b249.IDX = '0; b249.DIN_VALID = 1'b0; b249.INTENSITY = '0; b249.PHASE = '0;
    b8.START   = 1'b0; b8.IDX   = '0; b8.DIN_VALID   = 1'b0; b8.INTENSITY   = '0; b8.PHASE   = '0;
    b4.START   = 1'b0; b4.IDX   = '0; b4.DIN_VALID   = 1'b0; b4.INTENSITY   = '0; b4.PHASE   = '0;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Reset values
    check("rst_ready", 64'(b249.DIN_READY), 64'd0);
    check("rst_busy",  64'(b249.BUSY),      64'd0);
    check("rst_done",  64'(b249.DONE),      64'd0);
    check("rst_we",    64'(b249.BRAM_WE),   64'd0);
    check("rst_idx",   64'(b249.BRAM_IDX),  64'd0);
    check("rst_addr",  64'(b249.BRAM_ADDR), 64'd0);
    check("rst_wdata", b249.BRAM_WDATA,     64'd0);
    check("rst_cksum", b249.CHECKSUM,       64'd0);

    // DEPTH=249 ramp frame, back-to-back samples
    b249.IDX = 16'h0005; b249.START = 1'b1;
    tick();
    b249.START = 1'b0; b249.IDX = 16'hFFFF;
    check("t1_ready_on", 64'(b249.DIN_READY), 64'd1);
    check("t1_busy_on",  64'(b249.BUSY),      64'd1);
    for (int n = 0; n < 249; n++) begin
      b249.DIN_VALID = 1'b1; b249.PHASE = 8'(n); b249.INTENSITY = ~8'(n);
      tick();
    end
    b249.DIN_VALID = 1'b0;
    check("t1_last_we",    64'(b249.BRAM_WE),   64'd1);
    check("t1_last_done",  64'(b249.DONE),      64'd1);
    check("t1_last_addr",  64'(b249.BRAM_ADDR), 64'd62);
    check("t1_ready_off",  64'(b249.DIN_READY), 64'd0);
    check("t1_busy_off",   64'(b249.BUSY),      64'd0);
    repeat (3) tick();
    check("t1_nwrites", 64'(q249.size()), 64'd63);
    check("t1_ndone",   64'(done249),     64'd1);
    ck = '0;
    nw = (q249.size() < 63) ? q249.size() : 63;
    for (int w = 0; w < nw; w++) begin
      check($sformatf("t1_addr%0d", w), 64'(q249[w].addr), 64'(w));
      check($sformatf("t1_idx%0d", w),  64'(q249[w].idx),  64'h5);
      check($sformatf("t1_data%0d", w), q249[w].data,      exp249(w));
      check($sformatf("t1_done%0d", w), 64'(q249[w].done), (w == 62) ? 64'd1 : 64'd0);
      ck = ck ^ exp249(w);
    end
    if (nw == 63) begin
      check("t1_word0",  q249[0].data,  64'hFC03_FD02_FE01_FF00);
      check("t1_word62", q249[62].data, 64'h0000_0000_0000_07F8);
    end
    check("t1_cksum",     b249.CHECKSUM,       CK_EN ? ck : 64'd0);
    check("t1_hold_addr", 64'(b249.BRAM_ADDR), 64'd62);
    check("t1_hold_data", b249.BRAM_WDATA,     64'h0000_0000_0000_07F8);

    // DEPTH=8 with valid gaps and an ignored mid-frame START
    q8.delete(); done8 = 0;
    b8.IDX = 16'h0001; b8.START = 1'b1;
    tick();
    b8.START = 1'b0;
    for (int n = 0; n < 8; n++) begin
      b8.DIN_VALID = 1'b1; b8.INTENSITY = 8'(160 + n); b8.PHASE = 8'(16 + n);
      tick();
      if (n < 7) begin
        b8.DIN_VALID = 1'b0; b8.INTENSITY = 8'hEE; b8.PHASE = 8'hEE;
        if (n == 3) begin
          b8.START = 1'b1; b8.IDX = 16'h1234;
        end
        tick();
        b8.START = 1'b0;
        check($sformatf("t2_ready_gap%0d", n), 64'(b8.DIN_READY), 64'd1);
      end
    end
    b8.DIN_VALID = 1'b0;
    check("t2_last_done", 64'(b8.DONE),      64'd1);
    check("t2_ready_off", 64'(b8.DIN_READY), 64'd0);
    repeat (3) tick();
    check("t2_nwrites", 64'(q8.size()), 64'd2);
    check("t2_ndone",   64'(done8),     64'd1);
    if (q8.size() >= 2) begin
      check("t2_w0_data", q8[0].data,      64'hA313_A212_A111_A010);
      check("t2_w0_addr", 64'(q8[0].addr), 64'd0);
      check("t2_w0_idx",  64'(q8[0].idx),  64'h0001);
      check("t2_w0_done", 64'(q8[0].done), 64'd0);
      check("t2_w1_data", q8[1].data,      64'hA717_A616_A515_A414);
      check("t2_w1_addr", 64'(q8[1].addr), 64'd1);
      check("t2_w1_idx",  64'(q8[1].idx),  64'h0001);
      check("t2_w1_done", 64'(q8[1].done), 64'd1);
    end

    // DEPTH=8 reset after six samples, then a fresh frame
    q8.delete(); done8 = 0;
    b8.IDX = 16'h0002; b8.START = 1'b1;
    tick();
    b8.START = 1'b0;
    for (int n = 0; n < 6; n++) begin
      b8.DIN_VALID = 1'b1; b8.INTENSITY = 8'(176 + n); b8.PHASE = 8'(32 + n);
      tick();
    end
    b8.DIN_VALID = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t4_rst_ready", 64'(b8.DIN_READY), 64'd0);
    check("t4_rst_busy",  64'(b8.BUSY),      64'd0);
    check("t4_rst_idx",   64'(b8.BRAM_IDX),  64'd0);
    check("t4_rst_addr",  64'(b8.BRAM_ADDR), 64'd0);
    check("t4_rst_wdata", b8.BRAM_WDATA,     64'd0);
    repeat (3) tick();
    check("t4_nwrites", 64'(q8.size()), 64'd1);
    check("t4_ndone",   64'(done8),     64'd0);
    b8.IDX = 16'h0003; b8.START = 1'b1;
    tick();
    b8.START = 1'b0;
    for (int n = 0; n < 8; n++) begin
      b8.DIN_VALID = 1'b1; b8.INTENSITY = 8'(192 + n); b8.PHASE = 8'(48 + n);
      tick();
    end
    b8.DIN_VALID = 1'b0;
    repeat (3) tick();
    check("t4_nwrites2", 64'(q8.size()), 64'd3);
    check("t4_ndone2",   64'(done8),     64'd1);
    if (q8.size() >= 3) begin
      check("t4_w0_data", q8[1].data,      64'hC333_C232_C131_C030);
      check("t4_w0_addr", 64'(q8[1].addr), 64'd0);
      check("t4_w0_idx",  64'(q8[1].idx),  64'h0003);
      check("t4_w1_data", q8[2].data,      64'hC737_C636_C535_C434);
      check("t4_w1_addr", 64'(q8[2].addr), 64'd1);
    end

    // DEPTH=4 checksum frames
    b4.IDX = 16'h0007; b4.START = 1'b1;
    tick();
    b4.START = 1'b0;
    for (int n = 0; n < 4; n++) begin
      b4.DIN_VALID = 1'b1; b4.INTENSITY = 8'hFF; b4.PHASE = 8'hFF;
      tick();
    end
    b4.DIN_VALID = 1'b0;
    check("t5_f1_we",    64'(b4.BRAM_WE), 64'd1);
    check("t5_f1_done",  64'(b4.DONE),    64'd1);
    check("t5_f1_data",  b4.BRAM_WDATA,   64'hFFFF_FFFF_FFFF_FFFF);
    check("t5_f1_cksum", b4.CHECKSUM,     CK_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
    repeat (2) tick();
    check("t5_f1_hold",  b4.CHECKSUM,     CK_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
    b4.IDX = 16'h0008; b4.START = 1'b1;
    tick();
    b4.START = 1'b0;
    check("t5_f2_clear", b4.CHECKSUM, 64'd0);
    for (int n = 0; n < 4; n++) begin
      b4.DIN_VALID = 1'b1; b4.INTENSITY = 8'h00; b4.PHASE = 8'h00;
      tick();
    end
    b4.DIN_VALID = 1'b0;
    check("t5_f2_done",  64'(b4.DONE),     64'd1);
    check("t5_f2_data",  b4.BRAM_WDATA,    64'd0);
    check("t5_f2_idx",   64'(b4.BRAM_IDX), 64'h0008);
    check("t5_f2_cksum", b4.CHECKSUM,      64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
